// File: rtl/div_arbiter_if.sv
// div_arbiter_if: request/response handshake and divider-side bus of the
// shared-divider arbiter. The arbiter connects to the slave modport; the
// requesters and divider together form the master side.
interface div_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic [1:0]  req_signed;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_q;
  logic [31:0] resp_r;
  logic        resp_ovf;
  logic        resp_err;
  logic        div_en;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_busy;
  logic        div_done;
  logic        div_ovf;
  logic [31:0] div_q;
  logic [31:0] div_r;

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_signed, resp_ready,
    input  div_busy, div_done, div_ovf, div_q, div_r,
    output req_ready, resp_valid, resp_q, resp_r, resp_ovf, resp_err,
    output div_en, div_sign, div_a, div_b
  );

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_signed, resp_ready,
    output div_busy, div_done, div_ovf, div_q, div_r,
    input  req_ready, resp_valid, resp_q, resp_r, resp_ovf, resp_err,
    input  div_en, div_sign, div_a, div_b
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: two-port arbiter and sequencer for the shared 32-bit
// iterative divider. One request in flight at a time; the result is returned
// to the port that issued it. A watchdog turns a missing div_done into an
// error response after WAIT_MAX cycles.
// Optional feature: define DIV_ARB_RR_EN for round-robin tie-breaking;
// without it port 0 always wins a tie and there is no pointer register.
//
// state | meaning
// IDLE  | grant one requester, latch its operands on the handshake
// ISSUE | div_en high for this single cycle, watchdog cleared
// WAIT  | wait for div_done, or give up after WAIT_MAX cycles
// RESP  | hold result on the response bus until the owner consumes it
module div_arbiter #(
  parameter int WAIT_MAX = 40
) (
  input logic          clk_i,
  input logic          rst_i,
  div_arbiter_if.slave bus
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] WD_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        state_q;
  logic          port_q;
  logic          sign_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          div_en_q;
  logic [1:0]    resp_valid_q;
  logic [31:0]   resp_q_q;
  logic [31:0]   resp_r_q;
  logic          resp_ovf_q;
  logic          resp_err_q;
  logic [CW-1:0] wd_cnt_q;

  logic          gnt_any;
  logic          gnt_port;
  logic          unused_busy;

`ifdef DIV_ARB_RR_EN
  logic last_q;

  // Grant: a lone requester wins; on a tie serve the port not served last.
  always_comb begin
    gnt_any = |bus.req_valid;
    if (&bus.req_valid) gnt_port = ~last_q;
    else                gnt_port = ~bus.req_valid[0];
  end

  // Pointer remembers the port of every accepted request; port 1 after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)                              last_q <= 1'b1;
    else if (state_q == ST_IDLE && gnt_any) last_q <= gnt_port;
  end
`else
  // Grant: fixed priority, port 0 wins whenever it is requesting.
  always_comb begin
    gnt_any  = |bus.req_valid;
    gnt_port = ~bus.req_valid[0];
  end
`endif

  // Ready is offered only in IDLE and only to the granted port.
  assign bus.req_ready = (!rst_i && state_q == ST_IDLE && gnt_any) ?
                         {gnt_port, ~gnt_port} : 2'b00;

  // Sequencer: accept, pulse the divider, wait/watchdog, hold the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      port_q       <= 1'b0;
      sign_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      div_en_q     <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_q_q     <= '0;
      resp_r_q     <= '0;
      resp_ovf_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            port_q   <= gnt_port;
            a_q      <= gnt_port ? bus.req_a1 : bus.req_a0;
            b_q      <= gnt_port ? bus.req_b1 : bus.req_b0;
            sign_q   <= bus.req_signed[gnt_port];
            div_en_q <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          div_en_q <= 1'b0;
          wd_cnt_q <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.div_done) begin
            resp_q_q     <= bus.div_q;
            resp_r_q     <= bus.div_r;
            resp_ovf_q   <= bus.div_ovf;
            resp_err_q   <= 1'b0;
            resp_valid_q <= port_q ? 2'b10 : 2'b01;
            state_q      <= ST_RESP;
          end else if (wd_cnt_q == WD_LAST) begin
            // Divider never answered: report an error with a zeroed result.
            resp_q_q     <= '0;
            resp_r_q     <= '0;
            resp_ovf_q   <= 1'b0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= port_q ? 2'b10 : 2'b01;
            state_q      <= ST_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (bus.resp_ready[port_q]) begin
            resp_valid_q <= 2'b00;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operands come straight from the latched request so they cannot move
  // while the divider may still be sampling them.
  assign bus.div_en     = div_en_q;
  assign bus.div_sign   = sign_q;
  assign bus.div_a      = a_q;
  assign bus.div_b      = b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_q     = resp_q_q;
  assign bus.resp_r     = resp_r_q;
  assign bus.resp_ovf   = resp_ovf_q;
  assign bus.resp_err   = resp_err_q;

  // Divider busy is informational only; completion is signalled by div_done.
  assign unused_busy = bus.div_busy;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: bench for div_arbiter with a behavioural divider model,
// a table of directed vectors, hand-written corner sequences and random
// transactions checked against an arithmetic reference.
module tb_div_arbiter;
  localparam int WMAX = 40;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_arbiter_if bus ();

  div_arbiter #(.WAIT_MAX(WMAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic bit is_short(input logic [31:0] a, input logic [31:0] b, input bit s);
    if (b == 32'd0) return 1'b1;
    if (s) return mag(a) < mag(b);
    return a < b;
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] q, output logic [31:0] r, output logic ovf);
    ovf = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = 32'd0; ovf = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  // ---------------- divider model ----------------
  bit          withhold = 1'b0;
  int          force_lat = 0;
  int          pend = 0;
  int          last_lat = 0;
  logic [31:0] mq, mr;
  logic        movf;

  always @(negedge clk) begin
    bus.div_done = 1'b0;
    bus.div_q    = 32'hDEAD_BEEF;
    bus.div_r    = 32'hBAD0_CAFE;
    bus.div_ovf  = 1'b1;
    if (rst) begin
      pend = 0;
    end else if (bus.div_en) begin
      ref_div(bus.div_a, bus.div_b, bus.div_sign, mq, mr, movf);
      if (is_short(bus.div_a, bus.div_b, bus.div_sign)) last_lat = 1;
      else if (force_lat > 0)                          last_lat = force_lat;
      else                                             last_lat = $urandom_range(2, 34);
      pend = last_lat;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0 && !withhold) begin
        bus.div_done = 1'b1;
        bus.div_q    = mq;
        bus.div_r    = mr;
        bus.div_ovf  = movf;
      end
    end
    bus.div_busy = (pend > 0);
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no DUT event within bound (cycle %0d)", nm, cyc);
  endtask

  task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input bit s, input bit v);
    if (p == 0) begin bus.req_a0 = a; bus.req_b0 = b; end
    else        begin bus.req_a1 = a; bus.req_b1 = b; end
    bus.req_signed[p] = s;
    bus.req_valid[p]  = v;
  endtask

  // Raise a request, wait for the handshake, then check the one-cycle start.
  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                      input bit s, output int t_acc);
    bit got = 1'b0;
    t_acc = -1;
    @(negedge clk);
    drive_req(p, a, b, s, 1'b1);
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      if (bus.req_ready[p]) begin got = 1'b1; t_acc = cyc; end
      else @(negedge clk);
    end
    if (!got) begin
      timeout("accept");
      bus.req_valid[p] = 1'b0;
      return;
    end
    @(negedge clk);
    drive_req(p, ~a, ~b, ~s, 1'b0);
    #1;
    chk("div_en_pulse", bus.div_en, 32'd1);
    chk("div_a", bus.div_a, a);
    chk("div_b", bus.div_b, b);
    chk("div_sign", bus.div_sign, {31'd0, s});
  endtask

  task automatic wait_resp(input int p, output int t_resp);
    bit got = 1'b0;
    t_resp = -1;
    for (int k = 0; k < WMAX + 60 && !got; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) chk("div_en_single", bus.div_en, 32'd0);
      if (bus.resp_valid != 2'b00) begin got = 1'b1; t_resp = cyc; end
    end
    if (!got) begin
      timeout("resp_wait");
      return;
    end
    chk("resp_valid_port", bus.resp_valid, (p == 0) ? 32'd1 : 32'd2);
  endtask

  // exp_lat == 0 means: use the latency the divider model chose, plus 2.
  task automatic run_one(input int p, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input logic [31:0] q, input logic [31:0] r, input logic ovf,
                         input int exp_lat, input string nm);
    int ta, tr, el;
    send(p, a, b, s, ta);
    if (ta < 0) return;
    wait_resp(p, tr);
    if (tr < 0) return;
    el = (exp_lat == 0) ? last_lat + 2 : exp_lat;
    chk({nm, "_q"}, bus.resp_q, q);
    chk({nm, "_r"}, bus.resp_r, r);
    chk({nm, "_ovf"}, bus.resp_ovf, {31'd0, ovf});
    chk({nm, "_err"}, bus.resp_err, 32'd0);
    chk({nm, "_lat"}, tr - ta, el);
    if (bus.resp_ready[p]) begin
      @(negedge clk);
      #1;
      chk({nm, "_drop"}, bus.resp_valid, 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_ready"}, bus.req_ready, 32'd0);
    chk({nm, "_resp_valid"}, bus.resp_valid, 32'd0);
    chk({nm, "_resp_q"}, bus.resp_q, 32'd0);
    chk({nm, "_resp_r"}, bus.resp_r, 32'd0);
    chk({nm, "_resp_ovf"}, bus.resp_ovf, 32'd0);
    chk({nm, "_resp_err"}, bus.resp_err, 32'd0);
    chk({nm, "_div_en"}, bus.div_en, 32'd0);
    chk({nm, "_div_sign"}, bus.div_sign, 32'd0);
    chk({nm, "_div_a"}, bus.div_a, 32'd0);
    chk({nm, "_div_b"}, bus.div_b, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    int          lat;
    logic [31:0] q;
    logic [31:0] r;
    bit          ovf;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ta, tr, last, exp_p, hold;
    int rem[2];
    bit got, rdy, ordy;
    logic [31:0] a, b, q, r;
    logic ovf;
    bit s;
    int p, sel;

    tbl[0] = '{0, 32'd100,        32'd7,          1'b0, 5,  32'd14,         32'd2,          1'b0};
    tbl[1] = '{1, 32'hFFFF_FFF9,  32'd2,          1'b1, 6,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{0, 32'd1234,       32'd0,          1'b0, 1,  32'hFFFF_FFFF,  32'd0,          1'b1};
    tbl[3] = '{1, 32'hFFFF_FFFF,  32'd16,         1'b0, 33, 32'h0FFF_FFFF,  32'd15,         1'b0};
    tbl[4] = '{0, 32'd100,        32'hFFFF_FFF9,  1'b1, 2,  32'hFFFF_FFF2,  32'd2,          1'b0};
    tbl[5] = '{1, 32'd5,          32'd9,          1'b0, 1,  32'd0,          32'd5,          1'b0};
    tbl[6] = '{0, 32'hFFFF_FF9C,  32'd7,          1'b1, 34, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};

    rst = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_signed = 2'b00;
    bus.req_a0 = 32'd0; bus.req_a1 = 32'd0;
    bus.req_b0 = 32'd0; bus.req_b1 = 32'd0;
    bus.resp_ready = 2'b00;

    // Reset values, with both requesters asserting during reset.
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    bus.req_valid = 2'b00;
    rst = 1'b0;

    // Table of single transactions, consumer always ready.
    bus.resp_ready = 2'b11;
    for (int i = 0; i < 7; i++) begin
      force_lat = tbl[i].lat;
      run_one(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].ovf,
              tbl[i].lat + 2, "vec");
    end
    force_lat = 0;

    // Back-pressure: result held, other port blocked and its ready ignored.
    bus.resp_ready = 2'b10;
    force_lat = 3;
    send(0, 32'd100, 32'd7, 1'b0, ta);
    wait_resp(0, tr);
    chk("stall_first_q", bus.resp_q, 32'd14);
    drive_req(1, 32'd100, 32'd7, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", bus.resp_valid, 32'd1);
      chk("stall_q", bus.resp_q, 32'd14);
      chk("stall_r", bus.resp_r, 32'd2);
      chk("stall_req_ready", bus.req_ready, 32'd0);
    end
    @(negedge clk);
    bus.resp_ready[0] = 1'b1;
    #1;
    chk("stall_release_ready", bus.req_ready, 32'd0);
    @(negedge clk);
    #1;
    chk("stall_release_valid", bus.resp_valid, 32'd0);
    chk("stall_resume_ready", bus.req_ready, 32'd2);
    @(negedge clk);
    drive_req(1, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("stall_resume_div_en", bus.div_en, 32'd1);
    wait_resp(1, tr);
    chk("stall_resume_q", bus.resp_q, 32'd14);
    @(negedge clk);
    force_lat = 0;

    // Reset in the middle of a WAIT (divider silent).
    withhold = 1'b1;
    send(0, 32'd50, 32'd3, 1'b0, ta);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    withhold = 1'b0;

    // Watchdog expiry, then a normal transaction clears the error.
    withhold = 1'b1;
    send(1, 32'd77, 32'd5, 1'b0, ta);
    wait_resp(1, tr);
    if (tr >= 0) begin
      chk("wd_lat", tr - ta, WMAX + 2);
      chk("wd_err", bus.resp_err, 32'd1);
      chk("wd_q", bus.resp_q, 32'd0);
      chk("wd_r", bus.resp_r, 32'd0);
    end
    @(negedge clk);
    withhold = 1'b0;
    run_one(0, 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 0, "post_wd");

    // Arbitration: both ports requesting continuously, three requests each.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.resp_ready = 2'b11;
    bus.req_a0 = 32'd100;        bus.req_b0 = 32'd7;
    bus.req_a1 = 32'hFFFF_FFF9;  bus.req_b1 = 32'd2;
    bus.req_signed = 2'b10;
    bus.req_valid  = 2'b11;
    rem[0] = 3; rem[1] = 3;
    last = 1;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
        #1;
        if (bus.req_ready != 2'b00) got = 1'b1;
        else @(negedge clk);
      end
      if (!got) begin
        timeout("arb_accept");
        break;
      end
      if (rem[0] > 0 && rem[1] > 0) begin
`ifdef DIV_ARB_RR_EN
        exp_p = 1 - last;
`else
        exp_p = 0;
`endif
      end else begin
        exp_p = (rem[0] > 0) ? 0 : 1;
      end
      chk("arb_grant", bus.req_ready, (exp_p == 0) ? 32'd1 : 32'd2);
      last = exp_p;
      rem[exp_p]--;
      @(negedge clk);
      if (rem[exp_p] == 0) bus.req_valid[exp_p] = 1'b0;
      wait_resp(exp_p, tr);
      chk("arb_q", bus.resp_q, (exp_p == 0) ? 32'd14 : 32'hFFFF_FFFD);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);

    // Random transactions against the arithmetic reference.
    force_lat = 0;
    for (int i = 0; i < 40; i++) begin
      p   = $urandom_range(0, 1);
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)     b = 32'd0;
      else if (sel < 3) b = $urandom_range(1, 15);
      else              b = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
      s    = $urandom_range(0, 1);
      rdy  = $urandom_range(0, 1);
      ordy = $urandom_range(0, 1);
      if (p == 0) bus.resp_ready = {ordy, rdy};
      else        bus.resp_ready = {rdy, ordy};
      ref_div(a, b, s, q, r, ovf);
      run_one(p, a, b, s, q, r, ovf, 0, "rnd");
      if (!rdy) begin
        hold = $urandom_range(1, 4);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          #1;
          chk("rnd_hold_valid", bus.resp_valid, (p == 0) ? 32'd1 : 32'd2);
          chk("rnd_hold_q", bus.resp_q, q);
        end
        @(negedge clk);
        bus.resp_ready[p] = 1'b1;
        @(negedge clk);
        #1;
        chk("rnd_release", bus.resp_valid, 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
